// File: rtl/axi_burst_slave_mem.sv
// AXI4 burst slave backed by a word-addressed RAM: one INCR/FIXED burst of 1-256 beats at a time.
// Reads are registered with a one-beat prefetch so an unstalled burst streams at one beat per cycle.
module axi_burst_slave_mem #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1024
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ADDR_W-1:0]     s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_W-1:0]     s_axi_wdata,
  input  logic [DATA_W/8-1:0]   s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_W-1:0]     s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_W-1:0]     s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int BYTES = DATA_W / 8;
  localparam int SH    = $clog2(BYTES);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(BYTES - 1));

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

  state_t             state, state_next;
  logic [ADDR_W-1:0]  addr;
  logic [7:0]         len;
  logic [7:0]         cnt;
  logic               fixed;
  logic               err;
  logic               rd_done;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic [ADDR_W-1:0]  word_idx;
  logic [ADDR_W-1:0]  addr_next;
  logic               in_range;
  logic               is_last;
  logic               aw_hs, ar_hs, w_beat, r_take, r_issue;

  assign word_idx  = addr >> SH;
  assign in_range  = word_idx < ADDR_W'(DEPTH);
  assign addr_next = fixed ? addr : addr + ADDR_W'(BYTES);
  assign is_last   = (cnt == len);

  assign aw_hs   = s_axi_awvalid && s_axi_awready;
  assign ar_hs   = s_axi_arvalid && s_axi_arready;
  assign w_beat  = s_axi_wvalid && s_axi_wready;
  assign r_take  = s_axi_rvalid && s_axi_rready;
  // A new read beat is fetched whenever the output register is empty or being drained.
  assign r_issue = (state == RDATA) && !rd_done && (!s_axi_rvalid || s_axi_rready);

  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= state_next;
  end

  // Handshake outputs are held low while reset is asserted.
  always_comb begin
    state_next    = state;
    s_axi_awready = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = 2'b00;
    if (!areset) begin
      case (state)
        IDLE: begin
          s_axi_awready = 1'b1;
          s_axi_arready = !s_axi_awvalid;
          if (s_axi_awvalid)      state_next = WDATA;
          else if (s_axi_arvalid) state_next = RDATA;
        end
        WDATA: begin
          s_axi_wready = 1'b1;
          if (s_axi_wvalid && is_last) state_next = WRESP;
        end
        WRESP: begin
          s_axi_bvalid = 1'b1;
          s_axi_bresp  = err ? 2'b10 : 2'b00;
          if (s_axi_bready) state_next = IDLE;
        end
        RDATA: begin
          if (r_take && s_axi_rlast) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      addr         <= '0;
      len          <= '0;
      cnt          <= '0;
      fixed        <= 1'b0;
      err          <= 1'b0;
      rd_done      <= 1'b0;
      s_axi_rvalid <= 1'b0;
      s_axi_rlast  <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= 2'b00;
    end else begin
      if (aw_hs) begin
        addr    <= s_axi_awaddr & ALIGN_MASK;
        len     <= s_axi_awlen;
        fixed   <= (s_axi_awburst == 2'b00);
        cnt     <= '0;
        err     <= 1'b0;
        rd_done <= 1'b0;
      end else if (ar_hs) begin
        addr    <= s_axi_araddr & ALIGN_MASK;
        len     <= s_axi_arlen;
        fixed   <= (s_axi_arburst == 2'b00);
        cnt     <= '0;
        err     <= 1'b0;
        rd_done <= 1'b0;
      end

      // Burst length comes from awlen; wlast is only cross-checked.
      if (w_beat) begin
        if (!in_range || (s_axi_wlast != is_last)) err <= 1'b1;
        if (!is_last) begin
          cnt  <= cnt + 8'd1;
          addr <= addr_next;
        end
      end

      if (r_issue) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= in_range ? mem[word_idx[IDX_W-1:0]] : '0;
        s_axi_rresp  <= in_range ? 2'b00 : 2'b10;
        s_axi_rlast  <= is_last;
        if (is_last) begin
          rd_done <= 1'b1;
        end else begin
          cnt  <= cnt + 8'd1;
          addr <= addr_next;
        end
      end else if (r_take) begin
        s_axi_rvalid <= 1'b0;
        s_axi_rlast  <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (w_beat && in_range) begin
      for (int b = 0; b < BYTES; b++) begin
        if (s_axi_wstrb[b]) mem[word_idx[IDX_W-1:0]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_burst_slave_mem.sv
// Self-checking bench for axi_burst_slave_mem: directed bursts plus randomized bursts
// compared against a word-array memory model computed from the burst addressing rules.
module tb_axi_burst_slave_mem;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 1024;
  localparam int BUDGET = 2000;

  logic              aclk;
  logic              areset;
  logic [31:0]       awaddr;
  logic [7:0]        awlen;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;
  logic [63:0]       wdata;
  logic [7:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [63:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  int checks = 0;
  int passes = 0;

  logic [63:0] model [DEPTH];
  logic [63:0] wd [256];
  logic [7:0]  ws [256];
  logic        wl [256];

  axi_burst_slave_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset(areset),
    .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awburst(awburst),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arburst(arburst),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  function automatic logic [31:0] beatAddr(input logic [31:0] start, input logic [1:0] burst, input int k);
    logic [31:0] base;
    base = start & ~32'h7;
    return (burst == 2'b00) ? base : base + 32'(k) * 32'd8;
  endfunction

  function automatic bit inRange(input logic [31:0] a);
    return (a >> 3) < 32'(DEPTH);
  endfunction

  function automatic logic [63:0] modelWord(input logic [31:0] a);
    return inRange(a) ? model[int'(a >> 3)] : 64'd0;
  endfunction

  task automatic fillBeats(input int len, input bit randStrb);
    for (int i = 0; i <= len; i++) begin
      wd[i] = {$urandom(), $urandom()};
      ws[i] = randStrb ? 8'($urandom()) : 8'hFF;
      wl[i] = (i == len);
    end
  endtask

  task automatic doReset();
    areset = 1'b1;
    @(posedge aclk); #1;
    @(negedge aclk);
    checkOutput("rst_awready", awready, 0);
    checkOutput("rst_arready", arready, 0);
    checkOutput("rst_wready",  wready,  0);
    checkOutput("rst_bvalid",  bvalid,  0);
    checkOutput("rst_bresp",   bresp,   0);
    checkOutput("rst_rvalid",  rvalid,  0);
    checkOutput("rst_rlast",   rlast,   0);
    checkOutput("rst_rresp",   rresp,   0);
    checkOutput("rst_rdata",   rdata,   0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    checkOutput("idle_awready", awready, 1);
    checkOutput("idle_arready", arready, 1);
    checkOutput("idle_rvalid",  rvalid,  0);
    @(posedge aclk); #1;
  endtask

  // Model update happens up front; the expected bresp follows from beat addresses and the driven wlast.
  task automatic writeBurst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst, input bit chkAr);
    int t;
    logic expErr;
    logic [31:0] a;
    expErr = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      a = beatAddr(addr, burst, i);
      if (inRange(a)) begin
        for (int b = 0; b < 8; b++)
          if (ws[i][b]) model[int'(a >> 3)][b*8 +: 8] = wd[i][b*8 +: 8];
      end else begin
        expErr = 1'b1;
      end
      if (wl[i] != (i == int'(len))) expErr = 1'b1;
    end

    awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    t = 0;
    @(negedge aclk);
    while (!awready && t < BUDGET) begin @(negedge aclk); t++; end
    checkOutput("aw_wait", t < BUDGET, 1);
    if (chkAr) checkOutput("ar_blocked_by_aw", arready, 0);
    @(posedge aclk); #1;
    awvalid = 1'b0;

    for (int i = 0; i <= int'(len); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wvalid = 1'b0;
        @(posedge aclk); #1;
      end
      wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = wl[i];
      t = 0;
      @(negedge aclk);
      while (!wready && t < BUDGET) begin @(negedge aclk); t++; end
      checkOutput("w_wait", t < BUDGET, 1);
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;

    @(negedge aclk);
    checkOutput("b_latency", bvalid, 1);
    t = 0;
    while (!bvalid && t < BUDGET) begin @(negedge aclk); t++; end
    checkOutput("b_wait", t < BUDGET, 1);
    for (int d = 0; d < int'($urandom_range(0, 2)); d++) begin
      @(posedge aclk); #1;
      @(negedge aclk);
      checkOutput("b_hold", bvalid, 1);
    end
    checkOutput("bresp", bresp, expErr ? 2'b10 : 2'b00);
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
  endtask

  // mode 0: rready always high, 1: toggling, 2: random
  task automatic readBurst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst, input int mode);
    int t, k, cyc;
    logic [31:0] a;
    araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    t = 0;
    @(negedge aclk);
    while (!arready && t < BUDGET) begin @(negedge aclk); t++; end
    checkOutput("ar_wait", t < BUDGET, 1);
    @(posedge aclk); #1;
    arvalid = 1'b0;

    k = 0; cyc = 0;
    while (k <= int'(len) && cyc < BUDGET) begin
      case (mode)
        0:       rready = 1'b1;
        1:       rready = (cyc % 2 == 0);
        default: rready = 1'($urandom_range(0, 1));
      endcase
      @(negedge aclk);
      if (cyc == 0) begin
        checkOutput("r_bubble", rvalid, 0);
      end else if (rvalid) begin
        a = beatAddr(addr, burst, k);
        checkOutput("rdata", rdata, modelWord(a));
        checkOutput("rresp", rresp, inRange(a) ? 2'b00 : 2'b10);
        checkOutput("rlast", rlast, k == int'(len));
        if (rready) k++;
      end else begin
        checkOutput("rlast_without_rvalid", rlast, 0);
      end
      @(posedge aclk); #1;
      cyc++;
    end
    rready = 1'b0;
    checkOutput("r_wait", cyc < BUDGET, 1);
    if (mode == 0) checkOutput("r_cycles", 64'(cyc), 64'(int'(len) + 2));
    @(negedge aclk);
    checkOutput("r_end_rvalid", rvalid, 0);
    checkOutput("r_end_rlast", rlast, 0);
    @(posedge aclk); #1;
  endtask

  initial begin
    logic [31:0] ra;
    logic [7:0]  rl;
    logic [1:0]  rb;
    int          t;

    areset = 1'b1;
    awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    doReset();

    // Fill the whole RAM with 256-beat bursts so every model word is known.
    for (int w = 0; w < DEPTH / 256; w++) begin
      fillBeats(255, 1'b0);
      writeBurst(32'(w * 256 * 8), 8'd255, 2'b01, 1'b0);
    end
    $display("[TB] RAM filled");

    for (int i = 0; i < 4; i++) begin wd[i] = 64'(i + 1); ws[i] = 8'hFF; wl[i] = (i == 3); end
    writeBurst(32'h0, 8'd3, 2'b01, 1'b0);
    readBurst(32'h0, 8'd3, 2'b01, 1);

    wd[0] = 64'hAAAA_AAAA_BBBB_BBBB; ws[0] = 8'h0F; wl[0] = 1'b1;
    writeBurst(32'h8, 8'd0, 2'b01, 1'b0);
    readBurst(32'h8, 8'd0, 2'b01, 0);

    for (int i = 0; i < 3; i++) begin wd[i] = 64'(i + 7); ws[i] = 8'hFF; end
    wl[0] = 1'b0; wl[1] = 1'b1; wl[2] = 1'b1;
    writeBurst(32'h10, 8'd2, 2'b00, 1'b0);
    readBurst(32'h10, 8'd0, 2'b01, 0);

    readBurst(32'((DEPTH - 1) * 8), 8'd1, 2'b01, 0);
    fillBeats(1, 1'b0);
    writeBurst(32'((DEPTH - 1) * 8), 8'd1, 2'b01, 1'b0);
    readBurst(32'((DEPTH - 1) * 8), 8'd0, 2'b01, 2);

    fillBeats(1, 1'b0);
    writeBurst(32'hFFFF_FFF8, 8'd1, 2'b01, 1'b0);
    readBurst(32'hFFFF_FFFC, 8'd1, 2'b01, 2);

    $display("[TB] simultaneous AW/AR");
    araddr = 32'h20; arlen = 8'd3; arburst = 2'b01; arvalid = 1'b1;
    fillBeats(3, 1'b1);
    writeBurst(32'h20, 8'd3, 2'b01, 1'b1);
    readBurst(32'h20, 8'd3, 2'b01, 0);

    $display("[TB] reset during read");
    araddr = 32'h0; arlen = 8'd15; arburst = 2'b01; arvalid = 1'b1;
    t = 0;
    @(negedge aclk);
    while (!arready && t < BUDGET) begin @(negedge aclk); t++; end
    checkOutput("ar_wait_abort", t < BUDGET, 1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    rready = 1'b1;
    repeat (3) begin @(posedge aclk); #1; end
    @(negedge aclk);
    checkOutput("abort_rvalid_before", rvalid, 1);
    @(posedge aclk); #1;
    doReset();
    rready = 1'b0;
    readBurst(32'h0, 8'd7, 2'b01, 0);

    readBurst(32'h0, 8'd255, 2'b01, 2);
    readBurst(32'h18, 8'd3, 2'b00, 1);

    $display("[TB] random bursts");
    for (int n = 0; n < 24; n++) begin
      rl = 8'($urandom_range(0, 15));
      rb = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       ra = 32'((DEPTH - int'($urandom_range(1, 8))) * 8) + 32'($urandom_range(0, 7));
        1:       ra = 32'hFFFF_FFC0 + 32'($urandom_range(0, 63));
        default: ra = 32'($urandom_range(0, DEPTH - 1) * 8) + 32'($urandom_range(0, 7));
      endcase
      fillBeats(int'(rl), 1'b1);
      if ($urandom_range(0, 5) == 0) begin
        t = int'($urandom_range(0, int'(rl)));
        wl[t] = ~wl[t];
      end
      writeBurst(ra, rl, rb, 1'b0);
      readBurst(ra, rl, rb, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
